// File: rtl/rr_dispatch_pkg.sv
// rtl/rr_dispatch_pkg.sv - shared types for the round-robin flit dispatcher
package rr_dispatch_pkg;

  localparam int DISP_DATA_WIDTH = 32;

  typedef enum logic {
    DISP_IDLE   = 1'b0,
    DISP_LOCKED = 1'b1
  } disp_state_e;

  typedef struct packed {
    logic                       head;
    logic                       tail;
    logic [DISP_DATA_WIDTH-1:0] data;
  } flit_t;

endpackage

// File: rtl/rr_lane_picker.sv
// rtl/rr_lane_picker.sv - picks the first eligible lane after ptr, wrapping
module rr_lane_picker #(
  parameter int NUM_OUT      = 4,
  parameter int LOG2_NUM_OUT = 2
) (
  input  logic [NUM_OUT-1:0]      eligible,
  input  logic [LOG2_NUM_OUT-1:0] ptr,
  output logic [NUM_OUT-1:0]      grant,
  output logic [LOG2_NUM_OUT-1:0] index,
  output logic                    found
);

  logic [NUM_OUT-1:0]      rotated;
  logic [NUM_OUT-1:0]      first;
  logic [LOG2_NUM_OUT-1:0] src;

  // Bit 0 of the rotated mask is lane ptr+1; index arithmetic wraps since NUM_OUT is a power of 2.
  always_comb begin
    rotated = '0;
    grant   = '0;
    index   = '0;
    src     = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      src        = LOG2_NUM_OUT'(j) + ptr + LOG2_NUM_OUT'(1);
      rotated[j] = eligible[src];
    end
    first = rotated & ~(rotated - NUM_OUT'(1));
    for (int j = 0; j < NUM_OUT; j++) begin
      src        = LOG2_NUM_OUT'(j) + ptr + LOG2_NUM_OUT'(1);
      grant[src] = first[j];
    end
    for (int j = 0; j < NUM_OUT; j++) begin
      if (grant[j]) index = index | LOG2_NUM_OUT'(j);
    end
    found = |eligible;
  end

endmodule

// File: rtl/rr_dispatcher.sv
// rtl/rr_dispatcher.sv - one-to-many wormhole flit dispatcher with per-lane credits
module rr_dispatcher
  import rr_dispatch_pkg::*;
#(
  parameter int DATA_WIDTH   = DISP_DATA_WIDTH,
  parameter int NUM_OUT      = 4,
  parameter int LOG2_NUM_OUT = 2,
  parameter int CREDIT_MAX   = 4,
  parameter int CREDIT_W     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_head,
  input  logic                    in_tail,
  output logic [NUM_OUT-1:0]      out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_head,
  output logic                    out_tail,
  input  logic [NUM_OUT-1:0]      credit_return,
  output logic [LOG2_NUM_OUT-1:0] cur_sel,
  output logic                    busy,
  output logic                    err
);

  logic                    buf_valid_q, buf_valid_d;
  flit_t                   buf_q, buf_d;
  disp_state_e             state_q, state_d;
  logic [LOG2_NUM_OUT-1:0] ptr_q, ptr_d;
  logic [LOG2_NUM_OUT-1:0] cur_sel_q, cur_sel_d;
  logic [CREDIT_W-1:0]     credit_q [NUM_OUT];
  logic [CREDIT_W-1:0]     credit_d [NUM_OUT];
  logic                    err_q, err_d;
  logic [NUM_OUT-1:0]      out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_head_q, out_head_d;
  logic                    out_tail_q, out_tail_d;

  logic [NUM_OUT-1:0]      eligible;
  logic [NUM_OUT-1:0]      pick_grant;
  logic [LOG2_NUM_OUT-1:0] pick_idx;
  logic                    pick_found;
  logic [LOG2_NUM_OUT-1:0] lane;
  logic                    fire;
  logic                    accept;
  logic                    take;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_OUT; i++) eligible[i] = (credit_q[i] != '0);
  end

  rr_lane_picker #(
    .NUM_OUT      (NUM_OUT),
    .LOG2_NUM_OUT (LOG2_NUM_OUT)
  ) u_picker (
    .eligible (eligible),
    .ptr      (ptr_q),
    .grant    (pick_grant),
    .index    (pick_idx),
    .found    (pick_found)
  );

  // A locked packet may only use its own lane, even if that lane is starved.
  always_comb begin
    if (state_q == DISP_LOCKED) begin
      lane = cur_sel_q;
      fire = buf_valid_q && eligible[cur_sel_q];
    end else begin
      lane = pick_idx;
      fire = buf_valid_q && pick_found && (pick_grant != '0);
    end
  end

  assign in_ready = !buf_valid_q || fire;
  assign accept   = in_valid && in_ready;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_d       = buf_q;
    state_d     = state_q;
    ptr_d       = ptr_q;
    cur_sel_d   = cur_sel_q;
    err_d       = err_q;
    out_valid_d = '0;
    out_data_d  = out_data_q;
    out_head_d  = out_head_q;
    out_tail_d  = out_tail_q;
    take        = 1'b0;
    for (int i = 0; i < NUM_OUT; i++) credit_d[i] = credit_q[i];

    if (accept) begin
      buf_valid_d = 1'b1;
      buf_d.head  = in_head;
      buf_d.tail  = in_tail;
      buf_d.data  = in_data;
    end else if (fire) begin
      buf_valid_d = 1'b0;
    end

    if (fire) begin
      out_valid_d[lane] = 1'b1;
      out_data_d        = buf_q.data;
      out_head_d        = buf_q.head;
      out_tail_d        = buf_q.tail;
      case (state_q)
        DISP_IDLE: begin
          if (!buf_q.head) err_d = 1'b1;
          cur_sel_d = lane;
          ptr_d     = lane;
          if (!buf_q.tail) state_d = DISP_LOCKED;
        end
        DISP_LOCKED: begin
          if (buf_q.head) err_d = 1'b1;
          if (buf_q.tail) state_d = DISP_IDLE;
        end
        default: state_d = DISP_IDLE;
      endcase
    end

    for (int i = 0; i < NUM_OUT; i++) begin
      take = fire && (lane == LOG2_NUM_OUT'(i));
      case ({credit_return[i], take})
        2'b10: begin
          if (credit_q[i] == CREDIT_W'(CREDIT_MAX)) err_d = 1'b1;
          else credit_d[i] = credit_q[i] + CREDIT_W'(1);
        end
        2'b01:   credit_d[i] = credit_q[i] - CREDIT_W'(1);
        default: credit_d[i] = credit_q[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_q       <= '0;
      state_q     <= DISP_IDLE;
      ptr_q       <= LOG2_NUM_OUT'(NUM_OUT - 1);
      cur_sel_q   <= '0;
      err_q       <= 1'b0;
      out_valid_q <= '0;
      out_data_q  <= '0;
      out_head_q  <= 1'b0;
      out_tail_q  <= 1'b0;
      for (int i = 0; i < NUM_OUT; i++) credit_q[i] <= CREDIT_W'(CREDIT_MAX);
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_q       <= buf_d;
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cur_sel_q   <= cur_sel_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_head_q  <= out_head_d;
      out_tail_q  <= out_tail_d;
      for (int i = 0; i < NUM_OUT; i++) credit_q[i] <= credit_d[i];
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_head  = out_head_q;
  assign out_tail  = out_tail_q;
  assign cur_sel   = cur_sel_q;
  assign busy      = (state_q == DISP_LOCKED);
  assign err       = err_q;

endmodule

// File: tb/tb_rr_dispatcher.sv
// tb/tb_rr_dispatcher.sv - self-checking bench for rr_dispatcher
module tb_rr_dispatcher;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int LN = 2;
  localparam int CM = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_head = 1'b0;
  logic          in_tail = 1'b0;
  logic [N-1:0]  out_valid;
  logic [DW-1:0] out_data;
  logic          out_head;
  logic          out_tail;
  logic [N-1:0]  credit_return = '0;
  logic [LN-1:0] cur_sel;
  logic          busy;
  logic          err;

  typedef struct {
    logic [DW-1:0] data;
    logic          head;
    logic          tail;
  } tflit_t;

  typedef struct {
    int            lane;
    logic [DW-1:0] data;
    logic          head;
    logic          tail;
  } obs_t;

  tflit_t tx_q[$];
  obs_t   rx_q[$];
  obs_t   exp_q[$];
  int     checks   = 0;
  int     failures = 0;
  bit     auto_return = 0;
  bit     gaps = 0;

  rr_dispatcher #(
    .DATA_WIDTH   (DW),
    .NUM_OUT      (N),
    .LOG2_NUM_OUT (LN),
    .CREDIT_MAX   (CM),
    .CREDIT_W     (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_head       (in_head),
    .in_tail       (in_tail),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_head      (out_head),
    .out_tail      (out_tail),
    .credit_return (credit_return),
    .cur_sel       (cur_sel),
    .busy          (busy),
    .err           (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic int onehot_lane(input logic [N-1:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    credit_return = '0;
    auto_return = 0;
    gaps = 0;
    tx_q.delete();
    rx_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic add_pkt(input int len, input logic [DW-1:0] base);
    for (int i = 0; i < len; i++)
      tx_q.push_back('{base + DW'(i), (i == 0), (i == len - 1)});
  endtask

  // Drives queued flits honouring the handshake and logs every output flit.
  task automatic run(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      bit acc;
      if (tx_q.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_data  = tx_q[0].data;
        in_head  = tx_q[0].head;
        in_tail  = tx_q[0].tail;
      end else begin
        in_valid = 1'b0;
      end
      acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) void'(tx_q.pop_front());
      if (out_valid != '0)
        rx_q.push_back('{onehot_lane(out_valid), out_data, out_head, out_tail});
      credit_return = auto_return ? out_valid : '0;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== '0 || busy !== 1'b0 || err !== 1'b0 || cur_sel !== '0) begin
      failures++;
      $display("FAIL reset_ctrl got out_valid=%b busy=%b err=%b cur_sel=%0d exp 0000/0/0/0",
               out_valid, busy, err, cur_sel);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    checks++;
    if (out_data !== '0 || out_head !== 1'b0 || out_tail !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_flit got data=%h head=%b tail=%b exp 0", out_data, out_head, out_tail);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (dut.credit_q[i] !== CW'(CM)) begin
        failures++;
        $display("FAIL reset_credit lane=%0d got=%0d exp=%0d", i, dut.credit_q[i], CM);
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      logic [N-1:0]  exp_v;
      logic [DW-1:0] exp_d;
      exp_v = (c >= 2 && c <= 5) ? N'(1 << (c - 2)) : ((c == 8) ? N'(1) : N'(0));
      exp_d = 32'hD0 + DW'(c - 2);
      checks++;
      if (out_valid !== exp_v || (exp_v != '0 && out_data !== exp_d)) begin
        failures++;
        $display("FAIL rr_cycle%0d got valid=%b data=%h exp valid=%b data=%h",
                 c, out_valid, out_data, exp_v, exp_d);
      end
      if (c < 7) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("FAIL rr_in_ready cycle%0d got=%b exp=1", c, in_ready);
        end
      end
      in_valid = (c < 4 || c == 6);
      in_data  = 32'hD0 + DW'(c);
      in_head  = 1'b1;
      in_tail  = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_wormhole();
    logic busy_at [12];
    logic [LN-1:0] sel_at [12];
    int exp_l [4] = '{0, 0, 0, 1};
    do_reset();
    add_pkt(3, 32'hA0);
    add_pkt(1, 32'hA3);
    for (int k = 1; k < 12; k++) begin
      run(1);
      busy_at[k] = busy;
      sel_at[k]  = cur_sel;
    end
    checks++;
    if (busy_at[2] !== 1'b1 || busy_at[3] !== 1'b1 || busy_at[5] !== 1'b0) begin
      failures++;
      $display("FAIL worm_busy got=%b%b%b exp=110", busy_at[2], busy_at[3], busy_at[5]);
    end
    checks++;
    if (sel_at[2] !== LN'(0) || sel_at[5] !== LN'(1)) begin
      failures++;
      $display("FAIL worm_cur_sel got=%0d,%0d exp=0,1", sel_at[2], sel_at[5]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= rx_q.size()) begin
        failures++;
        $display("FAIL worm_flit%0d got=missing exp lane=%0d", i, exp_l[i]);
      end else if (rx_q[i].lane != exp_l[i] || rx_q[i].data !== 32'hA0 + DW'(i)) begin
        failures++;
        $display("FAIL worm_flit%0d got lane=%0d data=%h exp lane=%0d data=%h",
                 i, rx_q[i].lane, rx_q[i].data, exp_l[i], 32'hA0 + DW'(i));
      end
    end
  endtask

  task automatic test_credit_stall();
    do_reset();
    add_pkt(6, 32'hB0);
    run(10);
    checks++;
    if (rx_q.size() != CM || in_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL stall_state got sent=%0d in_ready=%b busy=%b exp sent=%0d in_ready=0 busy=1",
               rx_q.size(), in_ready, busy, CM);
    end
    credit_return = N'(1);
    run(2);
    checks++;
    if (rx_q.size() != CM + 1 || rx_q[rx_q.size()-1].data !== 32'hB4 || rx_q[rx_q.size()-1].lane != 0) begin
      failures++;
      $display("FAIL stall_one_more got sent=%0d last=%h exp sent=%0d last=b4",
               rx_q.size(), rx_q[rx_q.size()-1].data, CM + 1);
    end
    run(4);
    checks++;
    if (rx_q.size() != CM + 1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_exact got sent=%0d in_ready=%b exp sent=%0d in_ready=0",
               rx_q.size(), in_ready, CM + 1);
    end
  endtask

  task automatic test_credit_skip();
    int exp_l [15] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 0, 3};
    do_reset();
    add_pkt(4, 32'h100);
    add_pkt(4, 32'h200);
    add_pkt(4, 32'h300);
    run(25);
    for (int r = 0; r < CM; r++) begin
      credit_return = N'(1);
      run(1);
    end
    add_pkt(1, 32'h400);
    add_pkt(1, 32'h500);
    add_pkt(1, 32'h600);
    run(12);
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (i >= rx_q.size()) begin
        failures++;
        $display("FAIL skip_flit%0d got=missing exp lane=%0d", i, exp_l[i]);
      end else if (rx_q[i].lane != exp_l[i]) begin
        failures++;
        $display("FAIL skip_flit%0d got lane=%0d exp lane=%0d", i, rx_q[i].lane, exp_l[i]);
      end
    end
    checks++;
    if (dut.credit_q[0] !== CW'(CM - 1) || dut.credit_q[1] !== '0 || dut.credit_q[3] !== CW'(CM - 2)) begin
      failures++;
      $display("FAIL skip_credits got %0d/%0d/%0d exp %0d/0/%0d",
               dut.credit_q[0], dut.credit_q[1], dut.credit_q[3], CM - 1, CM - 2);
    end
    do_reset();
    add_pkt(1, 32'h700);
    run(1);
    credit_return = N'(1);
    run(1);
    checks++;
    if (out_valid !== N'(1) || dut.credit_q[0] !== CW'(CM) || err !== 1'b0) begin
      failures++;
      $display("FAIL fire_and_return got valid=%b credit=%0d err=%b exp valid=0001 credit=%0d err=0",
               out_valid, dut.credit_q[0], err, CM);
    end
  endtask

  task automatic test_errors();
    do_reset();
    credit_return = N'(4);
    run(1);
    checks++;
    if (err !== 1'b1 || dut.credit_q[2] !== CW'(CM)) begin
      failures++;
      $display("FAIL err_overflow got err=%b credit=%0d exp err=1 credit=%0d", err, dut.credit_q[2], CM);
    end
    run(3);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky got=%b exp=1", err);
    end
    do_reset();
    tx_q.push_back('{32'hE0, 1'b0, 1'b0});
    tx_q.push_back('{32'hE1, 1'b0, 1'b1});
    run(8);
    checks++;
    if (rx_q.size() != 2 || rx_q[0].lane != 0 || rx_q[1].lane != 0 || err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL err_body_idle got n=%0d err=%b busy=%b exp n=2 lanes 0,0 err=1 busy=0",
               rx_q.size(), err, busy);
    end
    do_reset();
    tx_q.push_back('{32'hF0, 1'b1, 1'b0});
    tx_q.push_back('{32'hF1, 1'b1, 1'b0});
    tx_q.push_back('{32'hF2, 1'b0, 1'b1});
    tx_q.push_back('{32'hF3, 1'b1, 1'b1});
    run(10);
    checks++;
    if (rx_q.size() != 4 || rx_q[1].lane != 0 || rx_q[2].lane != 0 || rx_q[3].lane != 1 || err !== 1'b1) begin
      failures++;
      $display("FAIL err_head_locked got n=%0d err=%b exp n=4 lanes 0,0,0,1 err=1", rx_q.size(), err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    add_pkt(6, 32'hC0);
    run(10);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL midrst_pre got busy=%b in_ready=%b exp 1/0", busy, in_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== '0 || in_ready !== 1'b1 || cur_sel !== '0) begin
      failures++;
      $display("FAIL midrst_post got busy=%b valid=%b in_ready=%b sel=%0d exp 0/0000/1/0",
               busy, out_valid, in_ready, cur_sel);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (dut.credit_q[i] !== CW'(CM)) begin
        failures++;
        $display("FAIL midrst_credit lane=%0d got=%0d exp=%0d", i, dut.credit_q[i], CM);
      end
    end
    rst = 1'b0;
    tx_q.delete();
  endtask

  // Credits are returned as soon as a flit is seen, so every lane stays eligible
  // and well-formed packets must go to lanes 0,1,2,3,0,... in arrival order.
  task automatic test_random();
    int npkt;
    int budget;
    do_reset();
    auto_return = 1;
    gaps = 1;
    npkt = 30;
    for (int k = 0; k < npkt; k++) begin
      int len;
      len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) begin
        tflit_t f;
        f.data = $urandom;
        f.head = (i == 0);
        f.tail = (i == len - 1);
        tx_q.push_back(f);
        exp_q.push_back('{k % N, f.data, f.head, f.tail});
      end
    end
    budget = 0;
    while (rx_q.size() < exp_q.size() && budget < 1000) begin
      run(1);
      budget++;
    end
    run(4);
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rand_count got=%0d exp=%0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i].lane != exp_q[i].lane || rx_q[i].data !== exp_q[i].data ||
          rx_q[i].head !== exp_q[i].head || rx_q[i].tail !== exp_q[i].tail) begin
        failures++;
        $display("FAIL rand_flit%0d got lane=%0d data=%h h=%b t=%b exp lane=%0d data=%h h=%b t=%b",
                 i, rx_q[i].lane, rx_q[i].data, rx_q[i].head, rx_q[i].tail,
                 exp_q[i].lane, exp_q[i].data, exp_q[i].head, exp_q[i].tail);
      end
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (dut.credit_q[i] !== CW'(CM)) begin
        failures++;
        $display("FAIL rand_credit lane=%0d got=%0d exp=%0d", i, dut.credit_q[i], CM);
      end
    end
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rand_final got err=%b busy=%b exp 0/0", err, busy);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_wormhole();
    test_credit_stall();
    test_credit_skip();
    test_errors();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
